seg_digit_scanner: RTL and testbench
====================================

# seg_digit_scanner

Time-multiplexed digit scanner feeding the BINARY_TO_7SEG_DISPLAY decoder.
- Accepts a packed multi-digit hex value through a valid/ready handshake.
- Double-buffers the value so it only changes on a frame boundary, so no torn frames.
- Cycles through the digits, presenting one 4-bit nibble per dwell period with a one-hot digit enable.
- Provides anti-ghosting dead time and optional leading-zero blanking.

## Interface
Parameters:
- NUM_DIGITS, 4: digits scanned; range 1–8.
- SCAN_DIV, 50000: clock cycles per digit dwell; ≥ 2.
- DEAD_CYCLES, 2: cycles at dwell start with all enables off; < SCAN_DIV.
- BLANK_LEADING, 1: 1 = suppress leading zero digits (digit 0 never blanked).

Ports (reset is synchronous, active-low; i_RST_N is sampled only on the rising edge of i_CLK):
- i_CLK  in  1  system clock.
- i_RST_N  in  1  synchronous active-low reset.
- i_VALUE  in  4*NUM_DIGITS  packed value; nibble k = digit k, digit 0 least significant.
- i_VALUE_VALID  in  1  producer holds i_VALUE.
- o_VALUE_READY  out  1  pending buffer empty; transfer on valid&&ready.
- o_BINARY  out  4  nibble for the active digit, to the decoder's i_BINARY.
- o_DIGIT_EN  out  NUM_DIGITS  one-hot active-high digit enable, all-zero during dead time or blanking.
- o_FRAME_DONE  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
Registers:
- disp_reg: displayed value.
- pend_reg / pend_full: pending value and its flag.
- div_cnt: 0..SCAN_DIV-1.
- dig_idx: 0..NUM_DIGITS-1.

Reset (i_RST_N low at a rising edge):
- disp_reg = 0, pend_full = 0, div_cnt = 0, dig_idx = 0.
- Outputs: o_BINARY = 0, o_DIGIT_EN = 0, o_FRAME_DONE = 0.
- Reset mid-transfer discards pend_reg.

Scan:
- div_cnt increments every cycle and wraps at SCAN_DIV-1.
- On wrap, dig_idx increments and wraps NUM_DIGITS-1 → 0.
- Boundary = div_cnt == SCAN_DIV-1 && dig_idx == NUM_DIGITS-1. o_FRAME_DONE is registered high for exactly that cycle.

Handshake:
- o_VALUE_READY = !pend_full (combinational from the register).
- Transfer when i_VALUE_VALID && o_VALUE_READY.
  - Not a boundary cycle: pend_reg ← i_VALUE, pend_full ← 1.
  - Boundary cycle: disp_reg ← i_VALUE directly; pend_full stays 0 (bypass).
- Boundary with pend_full: disp_reg ← pend_reg, pend_full ← 0. READY rises the next cycle.
- Producer must hold i_VALUE stable while VALID && !READY. VALID may drop without transfer.

Blanking:
- Digit k (k > 0) is blanked when BLANK_LEADING and disp_reg digits NUM_DIGITS-1..k are all zero.
- A blanked digit keeps o_DIGIT_EN all-zero for its whole dwell. o_BINARY still shows its nibble (0).

## Timing
- All outputs are registered and update on the rising edge after the counter state.
- o_BINARY = disp_reg nibble[dig_idx], valid from the first dwell cycle.
- o_DIGIT_EN:
  - all-zero while div_cnt < DEAD_CYCLES;
  - then bit dig_idx set (unless blanked) through div_cnt == SCAN_DIV-1.
- Dwell length: exactly SCAN_DIV cycles. Frame length: NUM_DIGITS*SCAN_DIV cycles.
- Latency from accepted value to display:
  - via pend_reg: the remainder of the current frame, loaded at the next boundary;
  - via bypass: first cycle of the next frame.
- Two enable bits are never high in the same cycle, including across a dwell change with DEAD_CYCLES = 0.

## Structure
- Shared package seg_pkg:
  - DIGIT_W = 4;
  - MAX_DIGITS = 8;
  - function digit_idx_w(n) = clog2 sizing for dig_idx.
- Sub-module scan_timer (div_cnt + dig_idx, outputs dig_idx, dead, dwell_end, frame_end).
- Top level holds the handshake, buffers, blanking and output registers.
- 7-segment decoding stays outside this block.

## Test plan
Bench parameters: NUM_DIGITS = 4, SCAN_DIV = 4, DEAD_CYCLES = 1, BLANK_LEADING = 1.

- Reset:
  - Assert i_RST_N = 0 for 3 cycles mid-scan → next edge o_DIGIT_EN = 0000, o_BINARY = 0, o_VALUE_READY = 1, dig_idx restarts at 0.
- Scan order:
  - Load 0x1234, wait one frame → per 4-cycle dwell: BINARY 4, 3, 2, 1.
  - EN per dwell: 0000 then 0001 ×3, then 0010, 0100, 1000.
  - o_FRAME_DONE pulses every 16 cycles.
- Back-pressure:
  - Send 0xAAAA mid-frame → READY drops; display unchanged until the boundary.
  - Hold 0x5555 VALID → accepted only after the boundary; 0x5555 is displayed one frame after 0xAAAA.
- Bypass:
  - Assert VALID with 0x0F0F exactly on the boundary cycle with pend_full = 0 → next frame shows 0x0F0F; READY never drops.
- Blanking:
  - Load 0x0070 → digits 3 and 2 EN stay all-zero; digit 1 shows 7; digit 0 shows 0 enabled.
  - Load 0x0000 → only digit 0 enabled.
- One-hot assertion:
  - Random VALID traffic for 10 frames → $onehot0(o_DIGIT_EN) every cycle.
  - Displayed value changes only after an o_FRAME_DONE cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and sizing helpers for the digit scanner.
package seg_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    // Width of the digit index register; a single digit still needs one bit.
    function automatic int digit_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell divider and digit index counter; flags dead time, dwell end and frame end.
module scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 2,
    localparam int IDX_W      = digit_idx_w(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] dig_idx,
    output logic             dead,
    output logic             dwell_end,
    output logic             frame_end
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (dwell_end) begin
            div_cnt <= '0;
            dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    assign dwell_end = (div_cnt == CNT_LAST);
    assign frame_end = dwell_end && (dig_idx == IDX_LAST);
    assign dead      = int'(div_cnt) < DEAD_CYCLES;

endmodule

// File: rtl/seg_digit_scanner.sv
// Multiplexed hex digit scanner: double-buffered value, one-hot digit enables,
// dead time and leading-zero blanking, all outputs registered.
module seg_digit_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int DEAD_CYCLES   = 2,
    parameter int BLANK_LEADING = 1
) (
    input  logic                          i_CLK,
    input  logic                          i_RST_N,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] i_VALUE,
    input  logic                          i_VALUE_VALID,
    output logic                          o_VALUE_READY,
    output logic [DIGIT_W-1:0]            o_BINARY,
    output logic [NUM_DIGITS-1:0]         o_DIGIT_EN,
    output logic                          o_FRAME_DONE
);

    localparam int IDX_W = digit_idx_w(NUM_DIGITS);

    logic [DIGIT_W*NUM_DIGITS-1:0] disp_reg;
    logic [DIGIT_W*NUM_DIGITS-1:0] pend_reg;
    logic                          pend_full;
    logic [IDX_W-1:0]              dig_idx;
    logic                          dead;
    logic                          dwell_end;
    logic                          frame_end;
    logic                          boundary;
    logic [NUM_DIGITS-1:0]         blank;
    logic                          upper_zero;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_scan_timer (
        .clk      (i_CLK),
        .rst_n    (i_RST_N),
        .dig_idx  (dig_idx),
        .dead     (dead),
        .dwell_end(dwell_end),
        .frame_end(frame_end)
    );

    assign boundary      = dwell_end && frame_end;
    assign o_VALUE_READY = !pend_full;

    // Value only swaps at a frame boundary; a transfer landing on the boundary bypasses pend_reg.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            disp_reg  <= '0;
            pend_reg  <= '0;
            pend_full <= 1'b0;
        end else if (boundary) begin
            if (pend_full) begin
                disp_reg  <= pend_reg;
                pend_full <= 1'b0;
            end else if (i_VALUE_VALID) begin
                disp_reg <= i_VALUE;
            end
        end else if (i_VALUE_VALID && !pend_full) begin
            pend_reg  <= i_VALUE;
            pend_full <= 1'b1;
        end
    end

    // Digit k blanks when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero && (disp_reg[DIGIT_W*k +: DIGIT_W] == '0);
            blank[k]   = (BLANK_LEADING != 0) && upper_zero;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            o_BINARY     <= '0;
            o_DIGIT_EN   <= '0;
            o_FRAME_DONE <= 1'b0;
        end else begin
            o_BINARY     <= disp_reg[DIGIT_W*dig_idx +: DIGIT_W];
            o_DIGIT_EN   <= (dead || blank[dig_idx]) ? '0 : NUM_DIGITS'(1) << dig_idx;
            o_FRAME_DONE <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Self-checking bench for seg_digit_scanner: frame-position model plus directed scenarios.
module tb_seg_digit_scanner;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int DC    = 1;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  bin;
    logic [3:0]  en;
    logic        fd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_digit_scanner #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .DEAD_CYCLES  (DC),
        .BLANK_LEADING(1)
    ) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_VALUE      (value),
        .i_VALUE_VALID(valid),
        .o_VALUE_READY(ready),
        .o_BINARY     (bin),
        .o_DIGIT_EN   (en),
        .o_FRAME_DONE (fd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame, shown value and a one-deep pending queue.
    int          pos = 0;
    int          dig;
    int          ph;
    bit          m_ok = 1'b0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend[$];
    logic [3:0]  e_bin = '0;
    logic [3:0]  e_en = '0;
    logic        e_fd = 1'b0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            pos = 0;
            m_disp = '0;
            m_pend.delete();
            e_bin = '0;
            e_en = '0;
            e_fd = 1'b0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            dig   = pos / SD;
            ph    = pos % SD;
            e_bin = 4'((m_disp >> (4 * dig)) & 15);
            if (ph < DC || (dig > 0 && (m_disp >> (4 * dig)) == 0)) e_en = '0;
            else e_en = 4'(1 << dig);
            e_fd = (pos == FRAME - 1);
            if (pos == FRAME - 1) begin
                if (m_pend.size() != 0) m_disp = m_pend.pop_front();
                else if (valid) m_disp = value;
            end else if (valid && m_pend.size() == 0) begin
                m_pend.push_back(value);
            end
            pos = (pos + 1) % FRAME;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            check("binary", bin, e_bin);
            check("digit_en", en, e_en);
            check("frame_done", fd, e_fd);
            check("ready", ready, (m_pend.size() == 0) ? 1 : 0);
            check("onehot0", $onehot0(en), 1);
        end
    end

    logic [3:0] cap_b [16];
    logic [3:0] cap_e [16];
    logic       cap_f [16];

    logic [3:0] t1234_b [16] = '{4, 4, 4, 4, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1};
    logic [3:0] t1234_e [16] = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8};
    logic [3:0] t0070_b [16] = '{0, 0, 0, 0, 7, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [3:0] t0070_e [16] = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [3:0] t0000_b [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [3:0] t0000_e [16] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic send(input logic [15:0] v);
        valid = 1'b1;
        value = v;
        for (int n = 0; n < 100; n++) begin
            if (ready) begin
                @(negedge clk);
                valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        check("send_timeout", 0, 1);
    endtask

    task automatic wait_fd();
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (fd) return;
        end
        check("fd_timeout", 0, 1);
    endtask

    task automatic capture();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cap_b[i] = bin;
            cap_e[i] = en;
            cap_f[i] = fd;
        end
    endtask

    task automatic cmp_frame(input string tag, input logic [3:0] eb [16],
                             input logic [3:0] ee [16]);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_bin"}, cap_b[i], eb[i]);
            check({tag, "_en"}, cap_e[i], ee[i]);
            check({tag, "_fd"}, cap_f[i], (i == 15) ? 1 : 0);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_en", en, 0);
        check("rst_bin", bin, 0);
        check("rst_ready", ready, 1);
        check("rst_fd", fd, 0);

        // Scan order
        send(16'h1234);
        wait_fd();
        capture();
        cmp_frame("scan_1234", t1234_b, t1234_e);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (fd) break;
        end
        check("frame_period", n, 16);

        // Back-pressure
        repeat (4) @(negedge clk);
        send(16'hAAAA);
        check("bp_ready_low", ready, 0);
        send(16'h5555);
        wait_fd();
        check("bp_aaaa_last", bin, 4'hA);
        @(negedge clk);
        check("bp_5555_first", bin, 4'h5);

        // Bypass on the counter's boundary cycle
        repeat (14) @(negedge clk);
        valid = 1'b1;
        value = 16'h0F0F;
        check("byp_ready", ready, 1);
        @(negedge clk);
        valid = 1'b0;
        check("byp_fd", fd, 1);
        check("byp_old_last", bin, 4'h5);
        check("byp_ready_after", ready, 1);
        @(negedge clk);
        check("byp_first", bin, 4'hF);

        // Blanking
        send(16'h0070);
        wait_fd();
        capture();
        cmp_frame("blank_0070", t0070_b, t0070_e);
        send(16'h0000);
        wait_fd();
        capture();
        cmp_frame("blank_0000", t0000_b, t0000_e);

        // Random traffic, value held while stalled
        for (int i = 0; i < 10 * FRAME; i++) begin
            @(negedge clk);
            if (!(valid && !ready)) begin
                valid = 1'($urandom_range(0, 1));
                value = 16'($urandom);
            end
        end
        valid = 1'b0;

        // Reset mid-scan
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_en", en, 0);
        check("mid_rst_bin", bin, 0);
        check("mid_rst_ready", ready, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (fd) break;
        end
        check("mid_rst_restart", n, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
